// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared definitions for the ALU arbiter slice. Holds the FSM state
//            encoding, default widths and the ALU opcode values used by
//            requesters and tests.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int OP_W_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [OP_W_DEF-1:0] ALU_ADD = 4'd0;
   localparam logic [OP_W_DEF-1:0] ALU_SUB = 4'd1;
   localparam logic [OP_W_DEF-1:0] ALU_AND = 4'd2;
   localparam logic [OP_W_DEF-1:0] ALU_OR  = 4'd3;
   localparam logic [OP_W_DEF-1:0] ALU_XOR = 4'd4;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Bundles the two requester channels, the two response channels
//            and the ALU/source-mux side of the arbiter.
// Ports    : slave  - seen from the arbiter
//            master - seen from the requesters/ALU environment
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OP_W  = OP_W_DEF
);
   // requester 0 (execute path)
   logic             req0_valid;
   logic             req0_ready;
   logic [OP_W-1:0]  req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_reg;
   logic [WIDTH-1:0] req0_imm;
   logic             req0_is_reg;
   // requester 1 (auxiliary unit)
   logic             req1_valid;
   logic             req1_ready;
   logic [OP_W-1:0]  req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_reg;
   logic [WIDTH-1:0] req1_imm;
   logic             req1_is_reg;
   // ALU and source mux
   logic             alu_valid;
   logic [OP_W-1:0]  alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_register;
   logic [WIDTH-1:0] alu_immediate;
   logic             alu_is_reg;
   logic [WIDTH-1:0] alu_result;
   // responses
   logic             rsp0_valid;
   logic [WIDTH-1:0] rsp0_data;
   logic             rsp0_ready;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp1_data;
   logic             rsp1_ready;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_reg, req0_imm, req0_is_reg,
      input  req1_valid, req1_op, req1_a, req1_reg, req1_imm, req1_is_reg,
      output req0_ready, req1_ready,
      output alu_valid, alu_op, alu_a, alu_register, alu_immediate, alu_is_reg,
      input  alu_result,
      output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      input  rsp0_ready, rsp1_ready
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_reg, req0_imm, req0_is_reg,
      output req1_valid, req1_op, req1_a, req1_reg, req1_imm, req1_is_reg,
      input  req0_ready, req1_ready,
      input  alu_valid, alu_op, alu_a, alu_register, alu_immediate, alu_is_reg,
      output alu_result,
      input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      output rsp0_ready, rsp1_ready
   );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_rr_arb2
// Purpose  : Two-way round-robin grant, purely combinational.
// Ports    : req[1:0]  - request vector
//            last      - index granted most recently
//            gnt_valid - at least one request present
//            gnt       - granted index
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt
);

   always_comb begin
      gnt_valid = |req;
      gnt       = 1'b0;
      case (req)
         2'b10:   gnt = 1'b1;
         // on a tie the requester that was not served last wins
         2'b11:   gnt = ~last;
         default: gnt = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU and its register/immediate source
//            mux between two requesters. Round-robin grant, one operation in
//            flight: accept (IDLE) -> issue to ALU (ISSUE) -> respond (RESP).
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - requester, ALU and response channels (slave modport)
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OP_W  = OP_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   state_t           r_state;
   logic             r_last;
   logic             r_gnt;
   logic [OP_W-1:0]  r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] r_imm;
   logic             r_is_reg;
   logic [WIDTH-1:0] r_result;

   logic             w_gnt_valid;
   logic             w_gnt;
   logic             w_accept;
   logic             w_rsp_ready;

   alu_arbiter_rr_arb2 u_arb (
      .req       ({bus.req1_valid, bus.req0_valid}),
      .last      (r_last),
      .gnt_valid (w_gnt_valid),
      .gnt       (w_gnt)
   );

   assign w_accept       = (r_state == ST_IDLE) && w_gnt_valid;
   assign bus.req0_ready = w_accept && !w_gnt;
   assign bus.req1_ready = w_accept &&  w_gnt;

   // ALU side is driven straight from the hold registers, so it only changes
   // when a new operation is captured and holds its value otherwise.
   assign bus.alu_valid     = (r_state == ST_ISSUE);
   assign bus.alu_op        = r_op;
   assign bus.alu_a         = r_a;
   assign bus.alu_register  = r_reg;
   assign bus.alu_immediate = r_imm;
   assign bus.alu_is_reg    = r_is_reg;

   assign bus.rsp0_valid = (r_state == ST_RESP) && !r_gnt;
   assign bus.rsp1_valid = (r_state == ST_RESP) &&  r_gnt;
   assign bus.rsp0_data  = r_result;
   assign bus.rsp1_data  = r_result;

   // the non-granted requester's ready is ignored
   assign w_rsp_ready = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_last   <= 1'b1;
         r_gnt    <= 1'b0;
         r_op     <= '0;
         r_a      <= '0;
         r_reg    <= '0;
         r_imm    <= '0;
         r_is_reg <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_gnt    <= w_gnt;
                  r_op     <= w_gnt ? bus.req1_op     : bus.req0_op;
                  r_a      <= w_gnt ? bus.req1_a      : bus.req0_a;
                  r_reg    <= w_gnt ? bus.req1_reg    : bus.req0_reg;
                  r_imm    <= w_gnt ? bus.req1_imm    : bus.req0_imm;
                  r_is_reg <= w_gnt ? bus.req1_is_reg : bus.req0_is_reg;
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_result <= bus.alu_result;
               r_state  <= ST_RESP;
            end
            ST_RESP: begin
               if (w_rsp_ready) begin
                  r_last  <= r_gnt;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Acts as both requesters,
//            the ALU and both response consumers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int W  = 32;
   localparam int OW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   m_last = 1;   // model: requester served most recently

   logic [OW-1:0] p_op    [2];
   logic [W-1:0]  p_a     [2];
   logic [W-1:0]  p_reg   [2];
   logic [W-1:0]  p_imm   [2];
   logic          p_isreg [2];
   logic          p_valid [2];
   logic          rsp_rdy [2];

   alu_arbiter_if #(.WIDTH(W), .OP_W(OW)) bus ();

   alu_arbiter #(.WIDTH(W), .OP_W(OW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return a + b;
      endcase
   endfunction

   // environment ALU behind the source mux
   assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a,
                                  bus.alu_is_reg ? bus.alu_register : bus.alu_immediate);

   function automatic logic [W-1:0] expect_of(input int n);
      return alu_fn(p_op[n], p_a[n], p_isreg[n] ? p_reg[n] : p_imm[n]);
   endfunction

   function automatic logic [W-1:0] rsp_data_of(input int n);
      return (n == 1) ? bus.rsp1_data : bus.rsp0_data;
   endfunction

   task automatic drive();
      bus.req0_valid = p_valid[0]; bus.req0_op = p_op[0]; bus.req0_a = p_a[0];
      bus.req0_reg = p_reg[0]; bus.req0_imm = p_imm[0]; bus.req0_is_reg = p_isreg[0];
      bus.req1_valid = p_valid[1]; bus.req1_op = p_op[1]; bus.req1_a = p_a[1];
      bus.req1_reg = p_reg[1]; bus.req1_imm = p_imm[1]; bus.req1_is_reg = p_isreg[1];
      bus.rsp0_ready = rsp_rdy[0];
      bus.rsp1_ready = rsp_rdy[1];
   endtask

   task automatic rand_payload(input int n);
      p_op[n]    = OW'($urandom_range(0, 4));
      p_a[n]     = $urandom;
      p_reg[n]   = $urandom;
      p_imm[n]   = $urandom;
      p_isreg[n] = 1'($urandom_range(0, 1));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      p_valid[0] = 1'b0; p_valid[1] = 1'b0;
      rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b0;
      drive();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      m_last = 1;
   endtask

   task automatic test_reset();
      logic [W*6+OW+8:0] obs;
      rand_payload(0); rand_payload(1);
      p_valid[0] = 1'b0; p_valid[1] = 1'b0;
      rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b0;
      drive();
      rst_n = 1'b0;
      tick(); tick();
      obs = {bus.req0_ready, bus.req1_ready, bus.alu_valid, bus.alu_op, bus.alu_a,
             bus.alu_register, bus.alu_immediate, bus.alu_is_reg,
             bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data, 2'b00};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0", obs);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.alu_valid, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release_idle: got %b required 000",
                  {bus.alu_valid, bus.rsp0_valid, bus.rsp1_valid});
      end
      m_last = 1;
   endtask

   task automatic test_req0_alone();
      p_op[0] = ALU_ADD; p_a[0] = 5; p_reg[0] = 7; p_imm[0] = 32'hdead; p_isreg[0] = 1'b1;
      p_valid[0] = 1'b1; p_valid[1] = 1'b0;
      rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b0;
      drive(); #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
         errors++;
         $display("FAIL req0_ready: got %b required 01", {bus.req1_ready, bus.req0_ready});
      end
      tick();
      p_valid[0] = 1'b0; p_a[0] = 99; p_reg[0] = 1;   // post-accept changes must not leak
      drive(); #1;
      checks++;
      if ({bus.alu_valid, bus.alu_is_reg, bus.alu_op, bus.alu_a, bus.alu_register} !==
          {1'b1, 1'b1, ALU_ADD, 32'd5, 32'd7}) begin
         errors++;
         $display("FAIL req0_issue: got v=%b isreg=%b op=%0d a=%0d reg=%0d required 1 1 0 5 7",
                  bus.alu_valid, bus.alu_is_reg, bus.alu_op, bus.alu_a, bus.alu_register);
      end
      tick();
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data} !== {2'b10, 32'd12}) begin
         errors++;
         $display("FAIL req0_resp: got v0=%b v1=%b data=%0d required 1 0 12",
                  bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data);
      end
      tick();
      checks++;
      if ({bus.rsp0_valid, bus.alu_valid} !== 2'b00) begin
         errors++;
         $display("FAIL req0_done: got %b required 00", {bus.rsp0_valid, bus.alu_valid});
      end
      m_last = 0;
   endtask

   task automatic test_req1_alone();
      p_op[1] = ALU_ADD; p_a[1] = 5; p_reg[1] = 32'h1234; p_imm[1] = 3; p_isreg[1] = 1'b0;
      p_valid[0] = 1'b0; p_valid[1] = 1'b1;
      rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
      drive(); #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         errors++;
         $display("FAIL req1_ready: got %b required 10", {bus.req1_ready, bus.req0_ready});
      end
      tick();
      p_valid[1] = 1'b0;
      drive(); #1;
      checks++;
      if ({bus.alu_valid, bus.alu_is_reg, bus.alu_immediate} !== {1'b1, 1'b0, 32'd3}) begin
         errors++;
         $display("FAIL req1_issue: got v=%b isreg=%b imm=%0d required 1 0 3",
                  bus.alu_valid, bus.alu_is_reg, bus.alu_immediate);
      end
      tick();
      checks++;
      if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_data} !== {2'b10, 32'd8}) begin
         errors++;
         $display("FAIL req1_resp: got v1=%b v0=%b data=%0d required 1 0 8",
                  bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_data);
      end
      tick();
      m_last = 1;
   endtask

   task automatic test_back_to_back();
      int w;
      logic [W-1:0] exp_d, exp_a;
      do_reset();
      rand_payload(0); rand_payload(1);
      p_valid[0] = 1'b1; p_valid[1] = 1'b1;
      rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = 1 - m_last;
         exp_d = expect_of(w);
         exp_a = p_a[w];
         drive(); #1;
         checks++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'(1 << w)) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: got %b required %b", k,
                     {bus.req1_ready, bus.req0_ready}, 2'(1 << w));
         end
         tick();
         rand_payload(w);   // the winner immediately presents its next operation
         drive(); #1;
         checks++;
         if ({bus.alu_valid, bus.alu_a, bus.req1_ready, bus.req0_ready} !== {1'b1, exp_a, 2'b00}) begin
            errors++;
            $display("FAIL b2b_issue[%0d]: got v=%b a=%h rdy=%b required 1 %h 00", k,
                     bus.alu_valid, bus.alu_a, {bus.req1_ready, bus.req0_ready}, exp_a);
         end
         tick();
         checks++;
         if ({bus.rsp1_valid, bus.rsp0_valid, rsp_data_of(w)} !== {2'(1 << w), exp_d}) begin
            errors++;
            $display("FAIL b2b_resp[%0d]: got v=%b data=%h required %b %h", k,
                     {bus.rsp1_valid, bus.rsp0_valid}, rsp_data_of(w), 2'(1 << w), exp_d);
         end
         tick();
         m_last = w;
      end
   endtask

   task automatic test_rsp_hold();
      logic [W-1:0] exp_d;
      do_reset();
      rand_payload(0);
      p_valid[0] = 1'b1; p_valid[1] = 1'b0;
      rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b1;   // requester 1's ready must be ignored
      exp_d = expect_of(0);
      drive(); tick();
      p_valid[0] = 1'b0;
      rand_payload(1); p_valid[1] = 1'b1;
      drive(); tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.req1_ready} !==
             {2'b10, exp_d, 1'b0}) begin
            errors++;
            $display("FAIL hold_resp[%0d]: got v0=%b v1=%b data=%h rdy1=%b required 1 0 %h 0",
                     i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.req1_ready, exp_d);
         end
         tick();
      end
      rsp_rdy[0] = 1'b1;
      drive(); #1;
      checks++;
      if ({bus.rsp0_valid, bus.req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL hold_release: got %b required 10", {bus.rsp0_valid, bus.req1_ready});
      end
      tick();
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         errors++;
         $display("FAIL hold_next_grant: got %b required 10", {bus.req1_ready, bus.req0_ready});
      end
      exp_d = expect_of(1);
      tick();
      p_valid[1] = 1'b0;
      drive(); tick();
      checks++;
      if ({bus.rsp1_valid, bus.rsp1_data} !== {1'b1, exp_d}) begin
         errors++;
         $display("FAIL hold_req1_resp: got v=%b data=%h required 1 %h",
                  bus.rsp1_valid, bus.rsp1_data, exp_d);
      end
      tick();
      m_last = 1;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] exp_d;
      do_reset();
      rand_payload(0);
      p_valid[0] = 1'b1;
      drive(); tick();
      p_valid[0] = 1'b0;
      drive(); tick();          // now in RESP with rsp0_ready low
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.alu_valid, bus.alu_a, bus.rsp0_data} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got v0=%b v1=%b av=%b a=%h d=%h required all 0",
                  bus.rsp0_valid, bus.rsp1_valid, bus.alu_valid, bus.alu_a, bus.rsp0_data);
      end
      tick();
      rst_n = 1'b1;
      rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
      drive(); tick();
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.alu_valid} !== 3'b000) begin
         errors++;
         $display("FAIL midreset_no_resp: got %b required 000",
                  {bus.rsp0_valid, bus.rsp1_valid, bus.alu_valid});
      end
      rand_payload(1); p_valid[1] = 1'b1;
      exp_d = expect_of(1);
      drive(); #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         errors++;
         $display("FAIL midreset_req1_ready: got %b required 10", {bus.req1_ready, bus.req0_ready});
      end
      tick();
      p_valid[1] = 1'b0;
      drive(); tick();
      checks++;
      if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_data} !== {2'b10, exp_d}) begin
         errors++;
         $display("FAIL midreset_req1_resp: got v1=%b v0=%b data=%h required 1 0 %h",
                  bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_data, exp_d);
      end
      tick();
      m_last = 1;
   endtask

   task automatic test_random();
      int w, d;
      logic [OW-1:0] s_op;
      logic [W-1:0]  s_a, s_reg, s_imm, exp_d;
      logic          s_isreg;
      for (int it = 0; it < 40; it++) begin
         for (int n = 0; n < 2; n++)
            if (!p_valid[n] && $urandom_range(0, 1) == 1) begin
               rand_payload(n); p_valid[n] = 1'b1;
            end
         if (!p_valid[0] && !p_valid[1]) begin
            d = $urandom_range(0, 1);
            rand_payload(d); p_valid[d] = 1'b1;
         end
         rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b0;
         w = (p_valid[0] && p_valid[1]) ? 1 - m_last : (p_valid[1] ? 1 : 0);
         s_op = p_op[w]; s_a = p_a[w]; s_reg = p_reg[w]; s_imm = p_imm[w]; s_isreg = p_isreg[w];
         exp_d = expect_of(w);
         drive(); #1;
         checks++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'(1 << w)) begin
            errors++;
            $display("FAIL rnd_grant[%0d]: got %b required %b", it,
                     {bus.req1_ready, bus.req0_ready}, 2'(1 << w));
         end
         tick();
         p_valid[w] = 1'b0;
         rand_payload(w);
         drive(); #1;
         checks++;
         if ({bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_register, bus.alu_immediate,
              bus.alu_is_reg} !== {1'b1, s_op, s_a, s_reg, s_imm, s_isreg}) begin
            errors++;
            $display("FAIL rnd_issue[%0d]: got op=%0d a=%h r=%h i=%h s=%b required %0d %h %h %h %b",
                     it, bus.alu_op, bus.alu_a, bus.alu_register, bus.alu_immediate,
                     bus.alu_is_reg, s_op, s_a, s_reg, s_imm, s_isreg);
         end
         tick();
         d = $urandom_range(0, 3);
         rsp_rdy[1 - w] = 1'($urandom_range(0, 1));
         for (int i = 0; i <= d; i++) begin
            if (i == d) rsp_rdy[w] = 1'b1;
            drive(); #1;
            checks++;
            if ({bus.rsp1_valid, bus.rsp0_valid, rsp_data_of(w), bus.req1_ready, bus.req0_ready}
                !== {2'(1 << w), exp_d, 2'b00}) begin
               errors++;
               $display("FAIL rnd_resp[%0d.%0d]: got v=%b data=%h rdy=%b required %b %h 00",
                        it, i, {bus.rsp1_valid, bus.rsp0_valid}, rsp_data_of(w),
                        {bus.req1_ready, bus.req0_ready}, 2'(1 << w), exp_d);
            end
            tick();
         end
         m_last = w;
      end
      p_valid[0] = 1'b0; p_valid[1] = 1'b0;
      drive();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_req0_alone();
      test_req1_alone();
      test_back_to_back();
      test_rsp_hold();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
